// File: rtl/gj_frame_scheduler.sv
// Frame scheduler for the gap junction core input stream: round-robin between two
// payload sources, one header plus PAYLOAD_WORDS payload words per frame, idle gap enforced.
module gj_frame_scheduler #(
    parameter int unsigned PAYLOAD_WORDS = 216,
    parameter logic [7:0]  HDR_CMD       = 8'h02,
    parameter logic [19:0] GAP_CYCLES    = 20'd20000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [31:0] s0_TDATA,
    input  logic        s0_TVALID,
    output logic        s0_TREADY,
    input  logic [31:0] s1_TDATA,
    input  logic        s1_TVALID,
    output logic        s1_TREADY,
    output logic [31:0] input_r_TDATA_0,
    output logic        input_r_TVALID_0,
    output logic        input_r_TLAST_0,
    input  logic        input_r_TREADY_0,
    output logic        grant,
    output logic        busy,
    output logic [15:0] frame_count
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned WC_W   = 14;
    localparam int unsigned GAP_W  = 20;
    localparam int unsigned FC_W   = 16;

    localparam logic [15:0]       HDR_LEN  = 16'(PAYLOAD_WORDS * 4);
    localparam logic [DATA_W-1:0] HEADER   = {HDR_CMD, 8'h00, HDR_LEN};
    localparam logic [WC_W-1:0]   LAST_IDX = WC_W'(PAYLOAD_WORDS - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_DRAIN   = 2'd2
    } state_t;

    state_t             state_q, state_nx;
    logic [DATA_W-1:0]  tdata_q, tdata_nx;
    logic               tvalid_q, tvalid_nx;
    logic               tlast_q, tlast_nx;
    logic               grant_q, grant_nx;
    logic               busy_q, busy_nx;
    logic [FC_W-1:0]    fc_q, fc_nx;
    logic [GAP_W-1:0]   gap_q, gap_nx;
    logic [WC_W-1:0]    wc_q, wc_nx;

    logic               free_c;
    logic               gap_done_c;
    logic               sel_valid_c;
    logic [DATA_W-1:0]  sel_data_c;
    logic               s0_ready_c, s1_ready_c;

    // State and output register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            grant_q  <= 1'b1;
            busy_q   <= 1'b0;
            fc_q     <= '0;
            gap_q    <= '0;
            wc_q     <= '0;
        end else begin
            state_q  <= state_nx;
            tdata_q  <= tdata_nx;
            tvalid_q <= tvalid_nx;
            tlast_q  <= tlast_nx;
            grant_q  <= grant_nx;
            busy_q   <= busy_nx;
            fc_q     <= fc_nx;
            gap_q    <= gap_nx;
            wc_q     <= wc_nx;
        end
    end

    // Next-state, output-register load and source handshake
    always_comb begin
        state_nx    = state_q;
        tdata_nx    = tdata_q;
        tvalid_nx   = tvalid_q;
        tlast_nx    = tlast_q;
        grant_nx    = grant_q;
        fc_nx       = fc_q;
        gap_nx      = gap_q;
        wc_nx       = wc_q;
        s0_ready_c  = 1'b0;
        s1_ready_c  = 1'b0;
        free_c      = !tvalid_q || input_r_TREADY_0;
        gap_done_c  = (gap_q == GAP_CYCLES);
        sel_valid_c = grant_q ? s1_TVALID : s0_TVALID;
        sel_data_c  = grant_q ? s1_TDATA  : s0_TDATA;

        case (state_q)
            ST_IDLE: begin
                if (!gap_done_c) begin
                    gap_nx = gap_q + GAP_W'(1);
                end
                if (gap_done_c && enable && (s0_TVALID || s1_TVALID)) begin
                    // Both requesting: hand the frame to the source that did not own the last one
                    grant_nx  = (s0_TVALID && s1_TVALID) ? !grant_q : s1_TVALID;
                    tdata_nx  = HEADER;
                    tvalid_nx = 1'b1;
                    tlast_nx  = 1'b0;
                    wc_nx     = '0;
                    state_nx  = ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: begin
                s0_ready_c = !grant_q && free_c;
                s1_ready_c = grant_q && free_c;
                if (free_c) begin
                    if (sel_valid_c) begin
                        tdata_nx  = sel_data_c;
                        tvalid_nx = 1'b1;
                        tlast_nx  = (wc_q == LAST_IDX);
                        wc_nx     = wc_q + WC_W'(1);
                        if (wc_q == LAST_IDX) begin
                            state_nx = ST_DRAIN;
                        end
                    end else begin
                        tvalid_nx = 1'b0;
                        tlast_nx  = 1'b0;
                    end
                end
            end
            ST_DRAIN: begin
                if (tvalid_q && input_r_TREADY_0) begin
                    tvalid_nx = 1'b0;
                    tlast_nx  = 1'b0;
                    fc_nx     = fc_q + FC_W'(1);
                    gap_nx    = '0;
                    state_nx  = ST_IDLE;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase

        busy_nx = (state_nx != ST_IDLE);
    end

    assign s0_TREADY        = s0_ready_c;
    assign s1_TREADY        = s1_ready_c;
    assign input_r_TDATA_0  = tdata_q;
    assign input_r_TVALID_0 = tvalid_q;
    assign input_r_TLAST_0  = tlast_q;
    assign grant            = grant_q;
    assign busy             = busy_q;
    assign frame_count      = fc_q;

endmodule

// File: tb/tb_gj_frame_scheduler.sv
// Bench for gj_frame_scheduler: transaction model of frames, gaps and round-robin grants
// checked every cycle, plus directed scenarios with literal expectations.
module tb_gj_frame_scheduler;

    localparam int unsigned PW  = 216;
    localparam int unsigned GAP = 8;
    localparam logic [31:0] HDR_LIT = 32'h02000360;
    localparam logic [31:0] HDR_EXP = {8'h02, 8'h00, 16'(PW * 4)};

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic [31:0] s0_TDATA = '0;
    logic        s0_TVALID = 1'b0;
    logic        s0_TREADY;
    logic [31:0] s1_TDATA = '0;
    logic        s1_TVALID = 1'b0;
    logic        s1_TREADY;
    logic [31:0] input_r_TDATA_0;
    logic        input_r_TVALID_0;
    logic        input_r_TLAST_0;
    logic        input_r_TREADY_0 = 1'b1;
    logic        grant;
    logic        busy;
    logic [15:0] frame_count;

    always #5 clk = ~clk;

    gj_frame_scheduler #(
        .PAYLOAD_WORDS (PW),
        .HDR_CMD       (8'h02),
        .GAP_CYCLES    (20'(GAP))
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .enable           (enable),
        .s0_TDATA         (s0_TDATA),
        .s0_TVALID        (s0_TVALID),
        .s0_TREADY        (s0_TREADY),
        .s1_TDATA         (s1_TDATA),
        .s1_TVALID        (s1_TVALID),
        .s1_TREADY        (s1_TREADY),
        .input_r_TDATA_0  (input_r_TDATA_0),
        .input_r_TVALID_0 (input_r_TVALID_0),
        .input_r_TLAST_0  (input_r_TLAST_0),
        .input_r_TREADY_0 (input_r_TREADY_0),
        .grant            (grant),
        .busy             (busy),
        .frame_count      (frame_count)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Each source emits a tagged, incrementing word stream
    function automatic logic [31:0] gen(input int s, input int idx);
        return {(s == 0) ? 8'hA0 : 8'hB1, 24'(idx)};
    endfunction

    int src_ptr [2];
    int exp_ptr [2];
    bit hs      [2];
    bit rand_ready = 1'b0;

    // Model state
    bit          m_in_frame, m_pending, m_grant, m_pend_grant;
    int          m_beat, m_fc, idle_run, neg_since_rst, first_hdr_neg, hdr_gap;
    int          hdr_count, bubbles, last_bubbles;
    bit          first_hdr_seen;
    logic [31:0] first_hdr_data;
    int          grant_log[$];
    bit          prev_stall;
    logic [31:0] prev_data;
    logic        prev_valid, prev_last;

    initial begin
        src_ptr[0] = 0; src_ptr[1] = 0;
        exp_ptr[0] = 0; exp_ptr[1] = 0;
        hs[0] = 1'b0;   hs[1] = 1'b0;
        hdr_count = 0;
    end

    // Compare process: outputs are stable here, half a cycle from the active edge
    always @(negedge clk) begin
        if (!reset) begin
            m_in_frame = 0; m_pending = 0; m_grant = 1'b1; m_beat = 0; m_fc = 0;
            idle_run = 0; neg_since_rst = 0; first_hdr_seen = 0; prev_stall = 0;
            grant_log.delete();
            chk("rst_tvalid", 32'(input_r_TVALID_0), 0);
            chk("rst_busy", 32'(busy), 0);
            chk("rst_grant", 32'(grant), 1);
        end else begin
            neg_since_rst++;
            if (prev_stall) begin
                chk("stall_tdata", input_r_TDATA_0, prev_data);
                chk("stall_tvalid", 32'(input_r_TVALID_0), 32'(prev_valid));
                chk("stall_tlast", 32'(input_r_TLAST_0), 32'(prev_last));
            end
            chk("frame_count", 32'(frame_count), 32'(16'(m_fc)));

            if (m_pending) begin
                m_pending  = 0;
                m_in_frame = 1;
                m_beat     = 0;
                m_grant    = m_pend_grant;
                hdr_gap    = idle_run;
                idle_run   = 0;
                bubbles    = 0;
                hdr_count++;
                grant_log.push_back(int'(m_grant));
                chk("hdr_tvalid", 32'(input_r_TVALID_0), 1);
                chk("hdr_tdata", input_r_TDATA_0, HDR_EXP);
                chk("hdr_busy", 32'(busy), 1);
                if (!first_hdr_seen) begin
                    first_hdr_seen = 1;
                    first_hdr_neg  = neg_since_rst;
                    first_hdr_data = input_r_TDATA_0;
                end
            end else if (!m_in_frame) begin
                chk("idle_tvalid", 32'(input_r_TVALID_0), 0);
                chk("idle_busy", 32'(busy), 0);
                idle_run++;
                // A frame may start once the gap has elapsed and an enabled request is present
                if (idle_run >= int'(GAP) + 1 && enable && (s0_TVALID || s1_TVALID)) begin
                    m_pending    = 1;
                    m_pend_grant = (s0_TVALID && s1_TVALID) ? !m_grant : s1_TVALID;
                end
            end else begin
                chk("frame_busy", 32'(busy), 1);
                if (!input_r_TVALID_0) bubbles++;
            end
            chk("grant", 32'(grant), 32'(m_grant));

            if (!(m_in_frame && m_grant == 1'b0)) chk("s0_tready_gated", 32'(s0_TREADY), 0);
            if (!(m_in_frame && m_grant == 1'b1)) chk("s1_tready_gated", 32'(s1_TREADY), 0);
            hs[0] = s0_TVALID && s0_TREADY;
            hs[1] = s1_TVALID && s1_TREADY;

            if (input_r_TVALID_0 && input_r_TREADY_0 && m_in_frame) begin
                if (m_beat == 0) begin
                    chk("beat_header", input_r_TDATA_0, HDR_EXP);
                    chk("beat_header_tlast", 32'(input_r_TLAST_0), 0);
                end else begin
                    chk("beat_payload", input_r_TDATA_0, gen(int'(m_grant), exp_ptr[m_grant]));
                    exp_ptr[m_grant]++;
                    chk("beat_tlast", 32'(input_r_TLAST_0), 32'(m_beat == int'(PW)));
                end
                m_beat++;
                if (m_beat == int'(PW) + 1) begin
                    m_in_frame   = 0;
                    m_fc++;
                    last_bubbles = bubbles;
                    chk("consumed_vs_emitted", 32'(src_ptr[m_grant]), 32'(exp_ptr[m_grant]));
                end
            end
            prev_stall = input_r_TVALID_0 && !input_r_TREADY_0;
            prev_data  = input_r_TDATA_0;
            prev_valid = input_r_TVALID_0;
            prev_last  = input_r_TLAST_0;
        end
    end

    // Advance one cycle; sources present their next word after an accepted transfer
    task automatic tick();
        @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            if (hs[s]) src_ptr[s]++;
            hs[s] = 1'b0;
        end
        s0_TDATA = gen(0, src_ptr[0]);
        s1_TDATA = gen(1, src_ptr[1]);
        if (rand_ready) input_r_TREADY_0 = 1'($urandom_range(0, 1));
    endtask

    task automatic run_frames(input int target, input int budget);
        int n = 0;
        while (m_fc < target && n < budget) begin
            tick();
            n++;
        end
        if (m_fc < target) chk("frame_timeout", 32'(m_fc), 32'(target));
    endtask

    task automatic wait_beat(input int beat, input int budget);
        int n = 0;
        while (!(m_in_frame && m_beat >= beat) && n < budget) begin
            tick();
            n++;
        end
        if (!(m_in_frame && m_beat >= beat)) chk("beat_timeout", 32'(m_beat), 32'(beat));
    endtask

    // Assert reset just after an edge, check the asynchronous clear, then release
    task automatic do_reset();
        tick();
        reset = 1'b0;
        src_ptr[0] = exp_ptr[0];
        src_ptr[1] = exp_ptr[1];
        hs[0] = 1'b0; hs[1] = 1'b0;
        s0_TDATA = gen(0, src_ptr[0]);
        s1_TDATA = gen(1, src_ptr[1]);
        #1;
        chk("async_tdata", input_r_TDATA_0, 32'h0);
        chk("async_tvalid", 32'(input_r_TVALID_0), 0);
        chk("async_tlast", 32'(input_r_TLAST_0), 0);
        chk("async_frame_count", 32'(frame_count), 0);
        chk("async_grant", 32'(grant), 1);
        chk("async_s0_tready", 32'(s0_TREADY), 0);
        repeat (2) tick();
        reset = 1'b1;
    endtask

    int h0;

    initial begin
        // Single-source frame straight out of reset
        enable = 1'b1; s0_TVALID = 1'b1; s1_TVALID = 1'b0; input_r_TREADY_0 = 1'b1;
        do_reset();
        run_frames(1, 2000);
        tick();
        chk("t1_frame_count", 32'(frame_count), 1);
        chk("t1_grant", 32'(grant), 0);
        chk("t1_first_header", first_hdr_data, HDR_LIT);
        // Header is loaded on the 9th edge after release, visible at the 10th sample
        chk("t1_first_header_cycle", 32'(first_hdr_neg), 10);
        chk("t1_bubbles", 32'(last_bubbles), 0);

        // Round-robin with both sources always requesting
        s0_TVALID = 1'b1; s1_TVALID = 1'b1;
        do_reset();
        run_frames(4, 4000);
        chk("t2_headers", 32'(grant_log.size() >= 4), 1);
        if (grant_log.size() >= 4) begin
            chk("t2_grant0", 32'(grant_log[0]), 0);
            chk("t2_grant1", 32'(grant_log[1]), 1);
            chk("t2_grant2", 32'(grant_log[2]), 0);
            chk("t2_grant3", 32'(grant_log[3]), 1);
        end
        chk("t2_gap", 32'(hdr_gap), 9);

        // Random backpressure on the core side
        rand_ready = 1'b1;
        run_frames(6, 8000);
        rand_ready = 1'b0;
        input_r_TREADY_0 = 1'b1;
        s0_TVALID = 1'b0; s1_TVALID = 1'b0;
        repeat (20) tick();

        // s1 frame with a 3-cycle source bubble while s0 also requests
        s1_TVALID = 1'b1;
        wait_beat(0, 50);
        s0_TVALID = 1'b1;
        wait_beat(50, 500);
        s1_TVALID = 1'b0;
        repeat (3) tick();
        s1_TVALID = 1'b1;
        run_frames(7, 1000);
        s0_TVALID = 1'b0; s1_TVALID = 1'b0;
        chk("t4_bubbles", 32'(last_bubbles), 3);
        chk("t4_grant", 32'(grant_log[grant_log.size() - 1]), 1);
        repeat (20) tick();

        // Enable gating and gap after re-enable
        enable = 1'b0; s0_TVALID = 1'b1;
        h0 = hdr_count;
        repeat (60) tick();
        chk("t5_no_header_disabled", 32'(hdr_count - h0), 0);
        enable = 1'b1;
        wait_beat(20, 100);
        enable = 1'b0;
        run_frames(8, 1000);
        h0 = hdr_count;
        repeat (40) tick();
        chk("t5_no_header_after_disable", 32'(hdr_count - h0), 0);
        chk("t5_frame_count", 32'(frame_count), 8);
        enable = 1'b1;

        // Reset in the middle of a frame
        wait_beat(100, 300);
        do_reset();
        run_frames(1, 2000);
        tick();
        chk("t6_frame_count", 32'(frame_count), 1);
        chk("t6_first_header", first_hdr_data, HDR_LIT);
        chk("t6_first_header_cycle", 32'(first_hdr_neg), 10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        n_bad++;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
